// File: rtl/slave_send_packet.sv
// Purpose : USB slave packet transmitter; wins the SIE TX port, sends the PID byte,
//           streams payload bytes from the endpoint TX FIFO for data PIDs, ends with STOP.
// Latency : request to PID write >= 3 cycles (REQ, PID_WAIT); each payload byte >= 4 cycles.
// Backpressure: every write waits for SCTxPortRdy and SCTxPortGnt; a GAP cycle follows each write.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   sendPacketEn, PID  start request and the PID to send (sampled in IDLE only)
//   TXFifoData/Empty/REn   endpoint TX FIFO read side (data valid 1 cycle after REn)
//   SCTxPortReq/Gnt/Rdy/WEn/Data/Cntl   SIE TX port arbiter interface
//   sendPacketRdy      idle and able to accept a request
//   TXByteCount        payload bytes sent in the last packet
//   txAbort            grant watchdog fired (only with SLAVE_SEND_PACKET_GNT_TIMEOUT_EN defined)
//
// Optional feature: define SLAVE_SEND_PACKET_GNT_TIMEOUT_EN to enable the grant watchdog.
module slave_send_packet #(
    parameter int MAX_PKT_BYTES = 64,
    parameter int GNT_TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sendPacketEn,
    input  logic [3:0] PID,
    input  logic [7:0] TXFifoData,
    input  logic       TXFifoEmpty,
    output logic       TXFifoREn,
    output logic       SCTxPortReq,
    input  logic       SCTxPortGnt,
    input  logic       SCTxPortRdy,
    output logic       SCTxPortWEn,
    output logic [7:0] SCTxPortData,
    output logic [7:0] SCTxPortCntl,
    output logic       sendPacketRdy,
    output logic [9:0] TXByteCount,
    output logic       txAbort
);

    if (MAX_PKT_BYTES < 1 || MAX_PKT_BYTES > 1023 || GNT_TIMEOUT < 1 || GNT_TIMEOUT > 65535) begin : gBadParams
        $error("slave_send_packet: parameter out of range");
    end

    localparam logic [9:0] MAX_CNT = 10'(MAX_PKT_BYTES);

    localparam logic [7:0] CNTL_START = 8'h01;
    localparam logic [7:0] CNTL_DATA  = 8'h02;
    localparam logic [7:0] CNTL_STOP  = 8'h03;

    typedef enum logic [3:0] {
        ST_START     = 4'd0,
        ST_IDLE      = 4'd1,
        ST_REQ       = 4'd2,
        ST_PID_WAIT  = 4'd3,
        ST_PID_GAP   = 4'd4,
        ST_CHK       = 4'd5,
        ST_FIFO_LAT  = 4'd6,
        ST_DATA_WAIT = 4'd7,
        ST_DATA_GAP  = 4'd8,
        ST_STOP_WAIT = 4'd9,
        ST_DONE      = 4'd10
    } state_t;

    state_t     state;
    state_t     nextState;

    logic [3:0] pidReg;
    logic [7:0] dataByte;
    logic       byteValid;

    // Next-value signals for every registered output and internal register.
    logic       renD;
    logic       reqD;
    logic       wenD;
    logic [7:0] dataD;
    logic [7:0] cntlD;
    logic       rdyD;
    logic [9:0] countD;
    logic [3:0] pidD;
    logic [7:0] byteD;
    logic       byteValidD;

    // A write may only launch when the SIE is ready and we still own the port.
    logic       txGo;
    // Data phase ends on an empty FIFO or a full packet.
    logic       chkStop;

    assign txGo    = SCTxPortRdy & SCTxPortGnt;
    assign chkStop = TXFifoEmpty | (TXByteCount == MAX_CNT);

`ifdef SLAVE_SEND_PACKET_GNT_TIMEOUT_EN
    localparam logic [15:0] GNT_LAST = 16'(GNT_TIMEOUT - 1);

    logic [15:0] gntCnt;
    logic [15:0] gntCntD;
    logic        abortD;
    logic        gntExpired;

    // The cycle that would bring the count to GNT_TIMEOUT is the one that aborts.
    assign gntExpired = (gntCnt == GNT_LAST);
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_START;
            TXFifoREn     <= 1'b0;
            SCTxPortReq   <= 1'b0;
            SCTxPortWEn   <= 1'b0;
            SCTxPortData  <= 8'h00;
            SCTxPortCntl  <= 8'h00;
            sendPacketRdy <= 1'b0;
            TXByteCount   <= 10'd0;
            pidReg        <= 4'h0;
            dataByte      <= 8'h00;
            byteValid     <= 1'b0;
        end else begin
            state         <= nextState;
            TXFifoREn     <= renD;
            SCTxPortReq   <= reqD;
            SCTxPortWEn   <= wenD;
            SCTxPortData  <= dataD;
            SCTxPortCntl  <= cntlD;
            sendPacketRdy <= rdyD;
            TXByteCount   <= countD;
            pidReg        <= pidD;
            dataByte      <= byteD;
            byteValid     <= byteValidD;
        end
    end

`ifdef SLAVE_SEND_PACKET_GNT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gntCnt  <= 16'd0;
            txAbort <= 1'b0;
        end else begin
            gntCnt  <= gntCntD;
            txAbort <= abortD;
        end
    end
`else
    assign txAbort = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        nextState = state;
        unique case (state)
            ST_START:     nextState = ST_IDLE;
            ST_IDLE:      if (sendPacketEn) nextState = ST_REQ;
            ST_REQ: begin
                if (SCTxPortGnt) nextState = ST_PID_WAIT;
`ifdef SLAVE_SEND_PACKET_GNT_TIMEOUT_EN
                else if (gntExpired) nextState = ST_IDLE;
`endif
            end
            ST_PID_WAIT:  if (txGo) nextState = ST_PID_GAP;
            // Only data PIDs (xx11) carry a payload.
            ST_PID_GAP:   nextState = (pidReg[1:0] == 2'b11) ? ST_CHK : ST_STOP_WAIT;
            ST_CHK:       nextState = chkStop ? ST_STOP_WAIT : ST_FIFO_LAT;
            ST_FIFO_LAT:  nextState = ST_DATA_WAIT;
            ST_DATA_WAIT: if (txGo) nextState = ST_DATA_GAP;
            ST_DATA_GAP:  nextState = ST_CHK;
            ST_STOP_WAIT: if (txGo) nextState = ST_DONE;
            ST_DONE:      nextState = ST_IDLE;
            default:      nextState = ST_START;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        renD       = 1'b0;
        reqD       = SCTxPortReq;
        wenD       = 1'b0;
        dataD      = 8'h00;
        cntlD      = 8'h00;
        rdyD       = 1'b0;
        countD     = TXByteCount;
        pidD       = pidReg;
        byteD      = dataByte;
        byteValidD = byteValid;
`ifdef SLAVE_SEND_PACKET_GNT_TIMEOUT_EN
        gntCntD    = gntCnt;
        abortD     = txAbort;
`endif
        unique case (state)
            ST_IDLE: begin
                rdyD = ~sendPacketEn;
                if (sendPacketEn) begin
                    pidD   = PID;
                    countD = 10'd0;
                    reqD   = 1'b1;
`ifdef SLAVE_SEND_PACKET_GNT_TIMEOUT_EN
                    gntCntD = 16'd0;
                    abortD  = 1'b0;
`endif
                end
            end
            ST_REQ: begin
`ifdef SLAVE_SEND_PACKET_GNT_TIMEOUT_EN
                if (!SCTxPortGnt) begin
                    if (gntExpired) begin
                        reqD   = 1'b0;
                        abortD = 1'b1;
                    end else begin
                        gntCntD = gntCnt + 16'd1;
                    end
                end
`endif
            end
            ST_PID_WAIT: begin
                if (txGo) begin
                    wenD  = 1'b1;
                    dataD = {~pidReg, pidReg};
                    cntlD = CNTL_START;
                end
            end
            ST_CHK: begin
                byteValidD = 1'b0;
                if (!chkStop) renD = 1'b1;
            end
            // The read strobe is registered, so the FIFO sees it at the end of
            // FIFO_LAT and its data is valid in the first DATA_WAIT cycle.
            // That first cycle captures it (and may write it straight through);
            // later stall cycles use the held copy.
            ST_DATA_WAIT: begin
                if (!byteValid) begin
                    byteD      = TXFifoData;
                    byteValidD = 1'b1;
                end
                if (txGo) begin
                    wenD   = 1'b1;
                    dataD  = byteValid ? dataByte : TXFifoData;
                    cntlD  = CNTL_DATA;
                    countD = TXByteCount + 10'd1;
                end
            end
            ST_STOP_WAIT: begin
                if (txGo) begin
                    wenD  = 1'b1;
                    dataD = 8'h00;
                    cntlD = CNTL_STOP;
                end
            end
            ST_DONE: reqD = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_slave_send_packet.sv
module tb_slave_send_packet;

    localparam int MAXB = 4;
    localparam int GTO  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sendPacketEn = 1'b0;
    logic [3:0] PID = 4'h0;
    logic [7:0] TXFifoData = 8'h00;
    logic       TXFifoEmpty;
    logic       TXFifoREn;
    logic       SCTxPortReq;
    logic       SCTxPortGnt = 1'b0;
    logic       SCTxPortRdy = 1'b0;
    logic       SCTxPortWEn;
    logic [7:0] SCTxPortData;
    logic [7:0] SCTxPortCntl;
    logic       sendPacketRdy;
    logic [9:0] TXByteCount;
    logic       txAbort;

    slave_send_packet #(.MAX_PKT_BYTES(MAXB), .GNT_TIMEOUT(GTO)) dut (
        .clk          (clk),
        .rst          (rst),
        .sendPacketEn (sendPacketEn),
        .PID          (PID),
        .TXFifoData   (TXFifoData),
        .TXFifoEmpty  (TXFifoEmpty),
        .TXFifoREn    (TXFifoREn),
        .SCTxPortReq  (SCTxPortReq),
        .SCTxPortGnt  (SCTxPortGnt),
        .SCTxPortRdy  (SCTxPortRdy),
        .SCTxPortWEn  (SCTxPortWEn),
        .SCTxPortData (SCTxPortData),
        .SCTxPortCntl (SCTxPortCntl),
        .sendPacketRdy(sendPacketRdy),
        .TXByteCount  (TXByteCount),
        .txAbort      (txAbort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // FIFO model: initial block owns the write side, the clocked block the read side.
    logic [7:0] fifoMem [0:255];
    logic [7:0] wrPtr = 8'd0;
    logic [7:0] rdPtr = 8'd0;
    assign TXFifoEmpty = (wrPtr == rdPtr);

    always @(posedge clk) begin
        if (TXFifoREn && !TXFifoEmpty) begin
            TXFifoData <= fifoMem[rdPtr];
            rdPtr      <= rdPtr + 8'd1;
        end
    end

    // Port monitor: logs writes and read strobes, checks per-event protocol rules.
    logic [15:0] wrQ[$];
    int   renCnt = 0;
    logic sampRdy = 1'b0, sampGnt = 1'b0, prevWEn = 1'b0;

    always @(posedge clk) begin
        sampRdy = SCTxPortRdy;
        sampGnt = SCTxPortGnt;
    end

    always @(negedge clk) begin
        if (SCTxPortWEn) begin
            wrQ.push_back({SCTxPortData, SCTxPortCntl});
            check("wen_rdy_gnt", {30'd0, sampRdy, sampGnt}, 32'd3);
            check("wen_gap", prevWEn, 0);
            check("wen_req", SCTxPortReq, 1);
        end
        if (TXFifoREn) begin
            renCnt++;
            check("ren_nonempty", TXFifoEmpty, 0);
        end
        prevWEn = SCTxPortWEn;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] nextBytes[$];

    task automatic checkResetOutputs(input string tag);
        check({tag, "_ren"},   TXFifoREn, 0);
        check({tag, "_req"},   SCTxPortReq, 0);
        check({tag, "_wen"},   SCTxPortWEn, 0);
        check({tag, "_data"},  SCTxPortData, 0);
        check({tag, "_cntl"},  SCTxPortCntl, 0);
        check({tag, "_rdy"},   sendPacketRdy, 0);
        check({tag, "_count"}, TXByteCount, 0);
        check({tag, "_abort"}, txAbort, 0);
    endtask

    // One full packet; rdyMode 0 = Rdy always 1, 1 = toggling, 2 = random Rdy and Gnt drops.
    task automatic runPacket(input logic [3:0] pid, input int nBytes, input int gntDelay,
                             input int rdyMode, input string tag);
        logic [7:0]  bytes[$];
        logic [15:0] expQ[$];
        logic [7:0]  b;
        int base, renBase, nSent, expRem, cyc;
        bit done;
        cyc = 0;
        while (!sendPacketRdy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_idle"}, sendPacketRdy, 1);
        wrPtr = rdPtr;
        for (int i = 0; i < nBytes; i++) begin
            if (nextBytes.size() > 0) b = nextBytes.pop_front();
            else b = 8'($urandom);
            bytes.push_back(b);
            fifoMem[wrPtr] = b;
            wrPtr = wrPtr + 8'd1;
        end
        // Reference: PID byte, up to MAXB payload bytes for data PIDs, then STOP.
        nSent = (pid[1:0] == 2'b11) ? ((nBytes < MAXB) ? nBytes : MAXB) : 0;
        expQ.push_back({~pid, pid, 8'h01});
        for (int i = 0; i < nSent; i++) expQ.push_back({bytes[i], 8'h02});
        expQ.push_back(16'h0003);
        expRem = nBytes - nSent;

        base = wrQ.size();
        renBase = renCnt;
        PID = pid;
        sendPacketEn = 1'b1;
        SCTxPortGnt = 1'b0;
        SCTxPortRdy = 1'b0;
        done = 0;
        cyc = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            sendPacketEn = 1'b0;
            PID = 4'($urandom);
            if (cyc > 0 && sendPacketRdy) done = 1;
            else begin
                if (rdyMode == 2) begin
                    SCTxPortGnt = (cyc == gntDelay) || (cyc > gntDelay && $urandom_range(0, 3) != 0);
                    SCTxPortRdy = 1'($urandom_range(0, 1));
                end else begin
                    SCTxPortGnt = (cyc >= gntDelay);
                    SCTxPortRdy = (rdyMode == 0) || (cyc % 2 == 0);
                end
            end
            cyc++;
        end
        check({tag, "_completed"}, done, 1);
        check({tag, "_nwrites"}, wrQ.size() - base, expQ.size());
        for (int i = 0; i < expQ.size(); i++)
            if (base + i < wrQ.size())
                check($sformatf("%s_wr%0d", tag, i), wrQ[base + i], expQ[i]);
        check({tag, "_nren"}, renCnt - renBase, nSent);
        check({tag, "_bytecount"}, TXByteCount, nSent);
        check({tag, "_fifo_left"}, 8'(wrPtr - rdPtr), expRem);
        check({tag, "_req_low"}, SCTxPortReq, 0);
        check({tag, "_abort"}, txAbort, 0);
    endtask

    initial begin
        int cyc, nData, base0, nStop;
        logic [3:0] rp;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetOutputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy_1cyc", sendPacketRdy, 0);
        @(negedge clk);
        check("rst_rdy_2cyc", sendPacketRdy, 1);

        runPacket(4'h2, 0, 3, 0, "ack");
        nextBytes = {8'hA1, 8'hB2, 8'hC3};
        runPacket(4'h3, 3, 1, 0, "data0");
        runPacket(4'hB, 0, 0, 0, "data1_empty");
        runPacket(4'h3, 6, 2, 1, "maxpkt");
        check("count_holds", TXByteCount, 4);

        for (int k = 0; k < 8; k++) begin
            rp = ($urandom_range(0, 1) == 1) ? {2'($urandom), 2'b11} : 4'($urandom);
            runPacket(rp, $urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 2),
                      $sformatf("rand%0d", k));
        end

        // Reset in the middle of a data packet.
        wrPtr = rdPtr;
        for (int i = 0; i < 4; i++) begin
            fifoMem[wrPtr] = 8'($urandom);
            wrPtr = wrPtr + 8'd1;
        end
        base0 = wrQ.size();
        SCTxPortGnt = 1'b1;
        SCTxPortRdy = 1'b1;
        PID = 4'h3;
        sendPacketEn = 1'b1;
        nData = 0;
        cyc = 0;
        while (nData < 2 && cyc < 200) begin
            @(negedge clk);
            sendPacketEn = 1'b0;
            if (SCTxPortWEn && SCTxPortCntl == 8'h02) nData++;
            cyc++;
        end
        check("rstmid_reached", nData, 2);
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("rstmid");
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_rdy_1cyc", sendPacketRdy, 0);
        @(negedge clk);
        check("rstmid_rdy_2cyc", sendPacketRdy, 1);
        repeat (3) @(negedge clk);
        nStop = 0;
        for (int i = base0; i < wrQ.size(); i++)
            if (wrQ[i][7:0] == 8'h03) nStop++;
        check("rstmid_no_stop", nStop, 0);
        check("rstmid_nwrites", wrQ.size() - base0, 3);
        wrPtr = rdPtr;

`ifdef SLAVE_SEND_PACKET_GNT_TIMEOUT_EN
        // Grant never arrives: watchdog must abort after GTO cycles in REQ.
        SCTxPortGnt = 1'b0;
        SCTxPortRdy = 1'b1;
        base0 = wrQ.size();
        PID = 4'h2;
        sendPacketEn = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            sendPacketEn = 1'b0;
            if (k == 10) begin
                check("to_abort_early", txAbort, 0);
                check("to_req_held", SCTxPortReq, 1);
            end
            if (k == 11) begin
                check("to_abort", txAbort, 1);
                check("to_req_drop", SCTxPortReq, 0);
            end
        end
        repeat (3) @(negedge clk);
        check("to_abort_holds", txAbort, 1);
        check("to_idle_rdy", sendPacketRdy, 1);
        check("to_no_writes", wrQ.size() - base0, 0);
        PID = 4'h2;
        sendPacketEn = 1'b1;
        @(negedge clk);
        sendPacketEn = 1'b0;
        check("to_abort_cleared", txAbort, 0);
        SCTxPortGnt = 1'b1;
        cyc = 0;
        while (!sendPacketRdy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("to_recover_rdy", sendPacketRdy, 1);
        check("to_recover_abort", txAbort, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
